// File: rtl/k580vt57_dma.sv
// k580vt57_dma: 4-channel 8257-style DMA controller feeding the CRT on ch2.
// Ports: clk/reset_n/ce; CPU port iaddr/idata/odata/iwe_n/ird_n;
// DMA side drq/dack/hrq/hlda/oaddr/strobes/tc.
// Optional macro DMA_AUTOLOAD_EN: ch3 reloads ch2 at its terminal count.
module k580vt57_dma #(
    parameter int NCH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [3:0]  iaddr,
    input  logic [7:0]  idata,
    output logic [7:0]  odata,
    input  logic        iwe_n,
    input  logic        ird_n,
    input  logic [3:0]  drq,
    output logic [3:0]  dack,
    output logic        hrq,
    input  logic        hlda,
    output logic [15:0] oaddr,
    output logic        omemr_n,
    output logic        omemw_n,
    output logic        oiord_n,
    output logic        oiowr_n,
    output logic        tc
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_S1   = 3'd2;
    localparam logic [2:0] ST_S2   = 3'd3;
    localparam logic [2:0] ST_S3   = 3'd4;
    localparam logic [2:0] ST_S4   = 3'd5;

    logic [NCH-1:0][15:0] addr;
    logic [NCH-1:0][13:0] cnt;
    logic [NCH-1:0][1:0]  cmode;
    logic [7:0]           mode;
    logic                 ff;
    logic                 update;
    logic [3:0]           tc_flag;
    logic                 iwe_q;
    logic                 ird_q;
    logic [2:0]           state;
    logic [1:0]           ch;
    logic [1:0]           last;

    logic                 we;
    logic                 rd;
    logic [NCH-1:0]       whit;
    logic [3:0]           req;
    logic [3:0]           req_next;
    logic [2:0]           win;
    logic [2:0]           win_next;
    logic                 last_byte;
    logic                 reload;
    logic                 stop;
    logic                 active;
    logic                 strobe;
    logic                 unused_mode;

    // Returns {found, channel}; rotating mode starts just after the
    // most recently served channel, so that channel ends up lowest.
    function automatic logic [2:0] pick(input logic [3:0] r,
                                        input logic       rot,
                                        input logic [1:0] lst);
        logic [2:0] res;
        logic [1:0] c;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            c = rot ? 2'(lst + 2'(i) + 2'd1) : 2'(i);
            if (r[c]) res = {1'b1, c};
        end
        return res;
    endfunction

    assign we        = iwe_n & ~iwe_q;
    assign rd        = ird_n & ~ird_q;
    assign req       = drq & mode[3:0];
    assign last_byte = (cnt[ch] == 14'd0);
`ifdef DMA_AUTOLOAD_EN
    assign reload    = mode[7] && (ch == 2'd2) && last_byte;
`else
    assign reload    = 1'b0;
`endif
    assign stop      = last_byte && mode[6] && !reload;
    assign req_next  = req & ~(stop ? (4'b0001 << ch) : 4'b0000);
    assign win       = pick(req, mode[4], last);
    assign win_next  = pick(req_next, mode[4], last);
    assign active    = (state == ST_S1) || (state == ST_S2) ||
                       (state == ST_S3) || (state == ST_S4);
    assign strobe    = (state == ST_S2) || (state == ST_S3);
    assign unused_mode = ^{mode[7], mode[5]};

    // Channels hit by a CPU register write; autoload mirrors ch2 into ch3.
    always_comb begin
        whit = '0;
        whit[iaddr[2:1]] = 1'b1;
`ifdef DMA_AUTOLOAD_EN
        if (mode[7] && (iaddr[2:1] == 2'd2)) whit[3] = 1'b1;
`endif
    end

    always_comb begin
        odata = 8'h00;
        if (!iaddr[3]) begin
            if (!iaddr[0])
                odata = ff ? addr[iaddr[2:1]][15:8] : addr[iaddr[2:1]][7:0];
            else
                odata = ff ? {cmode[iaddr[2:1]], cnt[iaddr[2:1]][13:8]}
                           : cnt[iaddr[2:1]][7:0];
        end else if (iaddr == 4'd8) begin
            odata = {3'b000, update, tc_flag};
        end
    end

    always_comb begin
        dack    = 4'b0000;
        oaddr   = 16'h0000;
        tc      = 1'b0;
        omemr_n = 1'b1;
        omemw_n = 1'b1;
        oiord_n = 1'b1;
        oiowr_n = 1'b1;
        if (active) begin
            dack[ch] = 1'b1;
            oaddr    = addr[ch];
            tc       = last_byte;
        end
        if (strobe) begin
            if (cmode[ch] == 2'b10) begin
                omemr_n = 1'b0;
                oiowr_n = 1'b0;
            end else if (cmode[ch] == 2'b01) begin
                oiord_n = 1'b0;
                omemw_n = 1'b0;
            end
        end
    end

    // CPU side first; the DMA S4 update comes later so it wins on conflict.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr    <= '0;
            cnt     <= '0;
            cmode   <= '0;
            mode    <= '0;
            ff      <= 1'b0;
            update  <= 1'b0;
            tc_flag <= '0;
            iwe_q   <= 1'b1;
            ird_q   <= 1'b1;
            state   <= ST_IDLE;
            ch      <= 2'd0;
            last    <= 2'd3;
            hrq     <= 1'b0;
        end else begin
            iwe_q <= iwe_n;
            ird_q <= ird_n;
            if (we) begin
                if (!iaddr[3]) begin
                    for (int i = 0; i < NCH; i++) begin
                        if (whit[i]) begin
                            if (!iaddr[0]) begin
                                if (ff) addr[i][15:8] <= idata;
                                else    addr[i][7:0]  <= idata;
                            end else if (ff) begin
                                cnt[i][13:8] <= idata[5:0];
                                cmode[i]     <= idata[7:6];
                            end else begin
                                cnt[i][7:0]  <= idata;
                            end
                        end
                    end
                    ff <= ~ff;
                end else if (iaddr == 4'd8) begin
                    mode <= idata;
                    ff   <= 1'b0;
                end
            end else if (rd) begin
                if (!iaddr[3]) begin
                    ff <= ~ff;
                end else if (iaddr == 4'd8) begin
                    tc_flag <= '0;
                    update  <= 1'b0;
                end
            end
            if (ce) begin
                unique case (state)
                    ST_IDLE: begin
                        if (|req) begin
                            hrq   <= 1'b1;
                            state <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (!(|req)) begin
                            hrq   <= 1'b0;
                            state <= ST_IDLE;
                        end else if (hlda) begin
                            ch    <= win[1:0];
                            last  <= win[1:0];
                            state <= ST_S1;
                        end
                    end
                    ST_S1: state <= ST_S2;
                    ST_S2: state <= ST_S3;
                    ST_S3: state <= ST_S4;
                    ST_S4: begin
                        if (reload) begin
                            addr[2]  <= addr[3];
                            cnt[2]   <= cnt[3];
                            cmode[2] <= cmode[3];
                            update   <= 1'b1;
                        end else begin
                            addr[ch] <= addr[ch] + 16'd1;
                            cnt[ch]  <= cnt[ch] - 14'd1;
                        end
                        if (last_byte) tc_flag[ch] <= 1'b1;
                        if (stop) mode[{1'b0, ch}] <= 1'b0;
                        if (win_next[2] && hlda) begin
                            ch    <= win_next[1:0];
                            last  <= win_next[1:0];
                            state <= ST_S1;
                        end else begin
                            hrq   <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_k580vt57_dma.sv
// tb_k580vt57_dma: randomized self-checking bench for k580vt57_dma.
// Transfers are logged at strobe assertion and compared to a queue model.
module tb_k580vt57_dma;

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] a;
        logic        t;
        logic        r;
        logic        ok;
    } xfer_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce;
    logic [3:0]  iaddr = 4'd0;
    logic [7:0]  idata = 8'd0;
    logic [7:0]  odata;
    logic        iwe_n = 1'b1;
    logic        ird_n = 1'b1;
    logic [3:0]  drq = 4'd0;
    logic [3:0]  dack;
    logic        hrq;
    logic        hlda;
    logic [15:0] oaddr;
    logic        omemr_n, omemw_n, oiord_n, oiowr_n;
    logic        tc;

    int    tests = 0;
    int    fails = 0;
    bit    ce_rand = 1'b0;
    bit    auto_hlda = 1'b0;
    logic  hlda_man = 1'b0;
    xfer_t log_q[$];
    logic  strb_q = 1'b0;
    logic  s_now;

    k580vt57_dma dut (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .iaddr(iaddr), .idata(idata), .odata(odata),
        .iwe_n(iwe_n), .ird_n(ird_n),
        .drq(drq), .dack(dack), .hrq(hrq), .hlda(hlda),
        .oaddr(oaddr),
        .omemr_n(omemr_n), .omemw_n(omemw_n),
        .oiord_n(oiord_n), .oiowr_n(oiowr_n),
        .tc(tc)
    );

    always #5 clk = ~clk;

    // CPU-side bus behaviour: hold acknowledge follows hrq, ce optionally random.
    initial begin
        ce = 1'b1;
        hlda = 1'b0;
        forever begin
            @(negedge clk);
            ce = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            hlda = auto_hlda ? hrq : hlda_man;
        end
    end

    assign s_now = reset_n && (!omemr_n || !omemw_n);

    function automatic int didx(input logic [3:0] d);
        for (int i = 0; i < 4; i++) if (d[i]) return i;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (s_now && !strb_q)
            log_q.push_back('{ch: 2'(didx(dack)), a: oaddr, t: tc,
                r: !omemr_n,
                ok: $onehot(dack) && (!omemr_n ?
                    (!oiowr_n && oiord_n && omemw_n) :
                    (!oiord_n && oiowr_n))});
        strb_q <= s_now;
    end

    function automatic xfer_t got(input int i);
        return (i < log_q.size()) ? log_q[i] : '0;
    endfunction

    task automatic do_reset;
        auto_hlda = 1'b0;
        hlda_man = 1'b0;
        ce_rand = 1'b0;
        drq = 4'd0;
        iwe_n = 1'b1;
        ird_n = 1'b1;
        iaddr = 4'd0;
        idata = 8'd0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        log_q.delete();
    endtask

    task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        iaddr = a;
        idata = d;
        iwe_n = 1'b0;
        @(negedge clk);
        iwe_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic cpu_rd(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        iaddr = a;
        ird_n = 1'b0;
        @(negedge clk);
        d = odata;
        ird_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic prog_ch(input int c, input logic [15:0] a,
                           input logic [15:0] n);
        cpu_wr(4'(c * 2), a[7:0]);
        cpu_wr(4'(c * 2), a[15:8]);
        cpu_wr(4'(c * 2 + 1), n[7:0]);
        cpu_wr(4'(c * 2 + 1), n[15:8]);
    endtask

    task automatic wait_hrq(input logic v, input string nm);
        int n = 0;
        while (hrq !== v && n < 6000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (hrq !== v) begin
            fails++;
            $display("FAIL %s: hrq=%b required=%b", nm, hrq, v);
        end
    endtask

    task automatic wait_tc(input string nm);
        int n = 0;
        while (tc !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (tc !== 1'b1) begin
            fails++;
            $display("FAIL %s: tc=%b required=1", nm, tc);
        end
    endtask

    task automatic test_reset;
        logic [7:0] d;
        do_reset;
        tests++;
        if ({hrq, dack, tc, oaddr} !== 22'd0) begin
            fails++;
            $display("FAIL reset_out: hrq=%b dack=%b tc=%b oaddr=%h required 0",
                     hrq, dack, tc, oaddr);
        end
        tests++;
        if ({omemr_n, omemw_n, oiord_n, oiowr_n} !== 4'hF) begin
            fails++;
            $display("FAIL reset_strobes: got=%b required=1111",
                     {omemr_n, omemw_n, oiord_n, oiowr_n});
        end
        cpu_rd(4'd8, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL reset_status: got=%h required=00", d);
        end
        cpu_rd(4'd5, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL reset_count: got=%h required=00", d);
        end
    endtask

    task automatic test_ff;
        logic [7:0] d;
        logic [7:0] b[4];
        int c;
        do_reset;
        cpu_wr(4'd0, 8'h34);
        cpu_wr(4'd0, 8'h12);
        cpu_rd(4'd0, d);
        tests++;
        if (d !== 8'h34) begin
            fails++;
            $display("FAIL ff_lo: got=%h required=34", d);
        end
        cpu_rd(4'd0, d);
        tests++;
        if (d !== 8'h12) begin
            fails++;
            $display("FAIL ff_hi: got=%h required=12", d);
        end
        cpu_rd(4'd0, d);
        cpu_wr(4'd8, 8'h00);
        cpu_rd(4'd0, d);
        tests++;
        if (d !== 8'h34) begin
            fails++;
            $display("FAIL ff_mode_clear: got=%h required=34", d);
        end
        cpu_rd(4'd0, d);
        for (int k = 0; k < 3; k++) begin
            c = $urandom_range(0, 3);
            for (int j = 0; j < 4; j++) b[j] = 8'($urandom);
            for (int j = 0; j < 4; j++) cpu_wr(4'(c * 2 + j / 2), b[j]);
            for (int j = 0; j < 4; j++) begin
                cpu_rd(4'(c * 2 + j / 2), d);
                tests++;
                if (d !== b[j]) begin
                    fails++;
                    $display("FAIL ff_rand ch%0d byte%0d: got=%h required=%h",
                             c, j, d, b[j]);
                end
            end
        end
    endtask

    task automatic test_crt_read;
        logic [7:0] d;
        xfer_t e;
        do_reset;
        prog_ch(2, 16'h76D0, 16'h804F);
        cpu_wr(4'd8, 8'h04);
        ce_rand = 1'b1;
        auto_hlda = 1'b1;
        drq = 4'b0100;
        wait_tc("crt_tc");
        drq = 4'b0000;
        wait_hrq(1'b0, "crt_idle");
        tests++;
        if (log_q.size() !== 80) begin
            fails++;
            $display("FAIL crt_count: got=%0d required=80", log_q.size());
        end
        for (int i = 0; i < 80; i++) begin
            e = '{ch: 2'd2, a: 16'h76D0 + 16'(i), t: (i == 79), r: 1'b1,
                  ok: 1'b1};
            tests++;
            if (got(i) !== e) begin
                fails++;
                $display("FAIL crt_xfer[%0d]: got=%h required=%h", i, got(i), e);
            end
        end
        ce_rand = 1'b0;
        auto_hlda = 1'b0;
        cpu_rd(4'd8, d);
        tests++;
        if (d !== 8'h04) begin
            fails++;
            $display("FAIL crt_status: got=%h required=04", d);
        end
        cpu_rd(4'd8, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL crt_status_clr: got=%h required=00", d);
        end
        cpu_rd(4'd4, d);
        cpu_rd(4'd4, e.a[15:8]);
        e.a[7:0] = d;
        tests++;
        if (e.a !== 16'h7720) begin
            fails++;
            $display("FAIL crt_addr_end: got=%h required=7720", e.a);
        end
    endtask

    task automatic test_random_xfer;
        logic [7:0]  d, d2;
        logic [15:0] a;
        logic [1:0]  md;
        int c, n;
        xfer_t e;
        for (int k = 0; k < 6; k++) begin
            do_reset;
            c  = $urandom_range(0, 3);
            a  = (k == 0) ? 16'hFFFD : 16'($urandom);
            n  = $urandom_range(0, 6);
            md = $urandom_range(0, 1) ? 2'b10 : 2'b01;
            prog_ch(c, a, {md, 14'(n)});
            cpu_wr(4'd8, 8'(1 << c));
            ce_rand = 1'b1;
            auto_hlda = 1'b1;
            drq = 4'($urandom) | 4'(1 << c);
            wait_tc("rnd_tc");
            drq = 4'b0000;
            wait_hrq(1'b0, "rnd_idle");
            tests++;
            if (log_q.size() !== n + 1) begin
                fails++;
                $display("FAIL rnd_count: got=%0d required=%0d",
                         log_q.size(), n + 1);
            end
            for (int i = 0; i <= n; i++) begin
                e = '{ch: 2'(c), a: a + 16'(i), t: (i == n),
                      r: (md == 2'b10), ok: 1'b1};
                tests++;
                if (got(i) !== e) begin
                    fails++;
                    $display("FAIL rnd_xfer[%0d]: got=%h required=%h",
                             i, got(i), e);
                end
            end
            cpu_rd(4'(c * 2 + 1), d);
            cpu_rd(4'(c * 2 + 1), d2);
            tests++;
            if ({d2, d} !== {md, 14'h3FFF}) begin
                fails++;
                $display("FAIL rnd_cnt_wrap: got=%h required=%h",
                         {d2, d}, {md, 14'h3FFF});
            end
        end
    endtask

    task automatic test_verify;
        logic [7:0] d;
        bit seen;
        do_reset;
        prog_ch(1, 16'h4000, 16'h0002);
        cpu_wr(4'd8, 8'h42);
        auto_hlda = 1'b1;
        drq = 4'b0010;
        wait_hrq(1'b1, "ver_hrq");
        wait_hrq(1'b0, "ver_idle");
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen |= hrq;
        end
        drq = 4'b0000;
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL ver_tcstop: hrq_seen=%b required=0", seen);
        end
        tests++;
        if (log_q.size() !== 0) begin
            fails++;
            $display("FAIL ver_strobes: got=%0d required=0", log_q.size());
        end
        cpu_rd(4'd8, d);
        tests++;
        if (d !== 8'h02) begin
            fails++;
            $display("FAIL ver_status: got=%h required=02", d);
        end
    endtask

    task automatic test_priority(input bit rot, input logic [3:0] fmask);
        logic [3:0]  mask;
        logic [15:0] base[4];
        logic [7:0]  d;
        int rem[4];
        int served[4];
        int lastm, c, j;
        bit seen;
        xfer_t exp_q[$];
        do_reset;
        mask = (fmask != 0) ? fmask : 4'($urandom_range(1, 15));
        for (int i = 0; i < 4; i++) begin
            base[i] = 16'($urandom);
            served[i] = 0;
            rem[i] = !mask[i] ? 0 : ((fmask != 0) ? 4 : $urandom_range(1, 4));
            if (mask[i]) prog_ch(i, base[i], {2'b10, 14'(rem[i] - 1)});
        end
        cpu_wr(4'd8, {3'b010, rot, mask});
        lastm = 3;
        while (1) begin
            c = -1;
            for (int k = 0; k < 4; k++) begin
                j = rot ? (lastm + 1 + k) % 4 : k;
                if (c < 0 && rem[j] > 0) c = j;
            end
            if (c < 0) break;
            exp_q.push_back('{ch: 2'(c), a: base[c] + 16'(served[c]),
                              t: (rem[c] == 1), r: 1'b1, ok: 1'b1});
            rem[c]--;
            served[c]++;
            lastm = c;
        end
        ce_rand = 1'b1;
        auto_hlda = 1'b1;
        drq = mask | 4'($urandom);
        wait_hrq(1'b1, "prio_hrq");
        wait_hrq(1'b0, "prio_idle");
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen |= hrq;
        end
        drq = 4'b0000;
        tests++;
        if (seen !== 1'b0 || log_q.size() !== exp_q.size()) begin
            fails++;
            $display("FAIL prio_count: got=%0d hrq_seen=%b required=%0d 0",
                     log_q.size(), seen, exp_q.size());
        end
        foreach (exp_q[i]) begin
            tests++;
            if (got(i) !== exp_q[i]) begin
                fails++;
                $display("FAIL prio_xfer[%0d] rot=%0d: got=%h required=%h",
                         i, rot, got(i), exp_q[i]);
            end
        end
        cpu_rd(4'd8, d);
        tests++;
        if (d !== {4'h0, mask}) begin
            fails++;
            $display("FAIL prio_status: got=%h required=%h", d, {4'h0, mask});
        end
    endtask

    task automatic test_autoload;
        logic [7:0]  d;
        logic [15:0] ea[6];
        logic [7:0]  est, r0, r1, r2, r3, w0, w1;
        logic        et[6];
        xfer_t e;
        int n = 0;
`ifdef DMA_AUTOLOAD_EN
        ea  = '{16'h1000, 16'h1001, 16'h8000, 16'h8001, 16'h8002, 16'h8003};
        et  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        est = 8'h14;
        {r0, r1, r2, r3} = {8'h00, 8'h80, 8'h03, 8'h80};
        {w0, w1} = {8'h55, 8'hAA};
`else
        ea  = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005};
        et  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        est = 8'h04;
        {r0, r1, r2, r3} = {8'h06, 8'h10, 8'hFB, 8'hBF};
        {w0, w1} = {8'h00, 8'h80};
`endif
        do_reset;
        prog_ch(2, 16'h1000, 16'h8001);
        prog_ch(3, 16'h8000, 16'h8003);
        cpu_wr(4'd8, 8'h84);
        ce_rand = 1'b1;
        auto_hlda = 1'b1;
        drq = 4'b0100;
        while (log_q.size() < 6 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        drq = 4'b0000;
        wait_hrq(1'b0, "al_idle");
        tests++;
        if (log_q.size() !== 6) begin
            fails++;
            $display("FAIL al_count: got=%0d required=6", log_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            e = '{ch: 2'd2, a: ea[i], t: et[i], r: 1'b1, ok: 1'b1};
            tests++;
            if (got(i) !== e) begin
                fails++;
                $display("FAIL al_xfer[%0d]: got=%h required=%h", i, got(i), e);
            end
        end
        cpu_rd(4'd8, d);
        tests++;
        if (d !== est) begin
            fails++;
            $display("FAIL al_status: got=%h required=%h", d, est);
        end
        cpu_rd(4'd4, d);
        cpu_rd(4'd4, e.a[15:8]);
        cpu_rd(4'd5, e.a[7:0]);
        tests++;
        if ({d, e.a[15:8], e.a[7:0]} !== {r0, r1, r2}) begin
            fails++;
            $display("FAIL al_regs: got=%h required=%h",
                     {d, e.a[15:8], e.a[7:0]}, {r0, r1, r2});
        end
        cpu_rd(4'd5, d);
        tests++;
        if (d !== r3) begin
            fails++;
            $display("FAIL al_cnt_hi: got=%h required=%h", d, r3);
        end
        cpu_wr(4'd4, 8'h55);
        cpu_wr(4'd4, 8'hAA);
        cpu_rd(4'd6, d);
        cpu_rd(4'd6, e.a[7:0]);
        tests++;
        if ({d, e.a[7:0]} !== {w0, w1}) begin
            fails++;
            $display("FAIL al_mirror: got=%h required=%h",
                     {d, e.a[7:0]}, {w0, w1});
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        bit seen;
        do_reset;
        prog_ch(2, 16'h2000, 16'h800A);
        cpu_wr(4'd8, 8'h04);
        auto_hlda = 1'b1;
        drq = 4'b0100;
        while (omemr_n !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (omemr_n !== 1'b0) begin
            fails++;
            $display("FAIL rm_reach_s2: omemr_n=%b required=0", omemr_n);
        end
        #1 reset_n = 1'b0;
        #1;
        tests++;
        if ({omemr_n, omemw_n, oiord_n, oiowr_n, hrq, dack} !== 9'b1111_0_0000) begin
            fails++;
            $display("FAIL rm_async: got=%b required=111100000",
                     {omemr_n, omemw_n, oiord_n, oiowr_n, hrq, dack});
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            seen |= hrq;
        end
        drq = 4'b0000;
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL rm_post_drq: hrq_seen=%b required=0", seen);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: sim_time=%0t required=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_ff;
        test_crt_read;
        test_random_xfer;
        test_verify;
        test_priority(1'b0, 4'b0101);
        test_priority(1'b1, 4'b0101);
        for (int k = 0; k < 4; k++) test_priority(1'($urandom_range(0, 1)), 4'b0000);
        test_autoload;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
